// File: rtl/control_seq.sv
// Registered instruction decoder/sequencer: accepts one instruction per
// valid/ready handshake and presents its control word on the following cycle.
module control_seq #(
    parameter int OPW     = 9,
    parameter int RAW     = 4,
    parameter int MEM_LAT = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           flush,
    input  logic           instr_valid,
    input  logic [OPW-1:0] instr,
    input  logic           br_done,
    output logic           instr_ready,
    output logic           ctl_valid,
    output logic           Branch,
    output logic           MemtoReg,
    output logic           MemWrite,
    output logic           ALUSrc,
    output logic           RegWrite,
    output logic           FlagWrite,
    output logic           Immed,
    output logic           illegal,
    output logic [2:0]     Flag,
    output logic [RAW-1:0] ReadAddr1,
    output logic [RAW-1:0] ReadAddr2,
    output logic [RAW-1:0] WriteAddr,
    output logic [4:0]     ALUOp,
    output logic [1:0]     dbg_state,
    output logic [3:0]     dbg_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] LWAIT = 2'd1;
    localparam logic [1:0] BWAIT = 2'd2;

    localparam int CW = 12 + 3 * RAW + 5;
    localparam logic [RAW-1:0] RA1_BUB = RAW'(8);
    localparam logic [RAW-1:0] RA2_BUB = RAW'(9);
    localparam logic [CW-1:0] BUBBLE =
        {9'b0, 3'b0, RA1_BUB, RA2_BUB, {RAW{1'b0}}, 5'b11111};
    localparam logic [CW-1:0] ILL_WORD =
        {1'b1, 7'b0, 1'b1, 3'b0, RA1_BUB, RA2_BUB, {RAW{1'b0}}, 5'b11111};

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [CW-1:0] ctl_q;
    logic [8:0]    i;
    logic          hi_nz;
    logic          accept;

    logic          d_branch, d_memtoreg, d_memwrite, d_alusrc, d_regwrite;
    logic          d_flagwrite, d_immed, d_bad, d_load, d_isbr;
    logic [2:0]    d_flag;
    logic [RAW-1:0] d_ra1, d_ra2, d_wa;
    logic [4:0]    d_aluop;
    logic [CW-1:0] d_word;

    assign i = instr[8:0];

    if (OPW > 9) begin : g_hi
        assign hi_nz = |instr[OPW-1:9];
    end else begin : g_nohi
        assign hi_nz = 1'b0;
    end

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; ready is low in reset, during flush and while stalled.
    assign instr_ready = Reset && !flush && (state == RUN);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        d_branch    = 1'b0;
        d_memtoreg  = 1'b0;
        d_memwrite  = 1'b0;
        d_alusrc    = 1'b0;
        d_regwrite  = 1'b0;
        d_flagwrite = 1'b0;
        d_immed     = 1'b0;
        d_bad       = 1'b0;
        d_load      = 1'b0;
        d_isbr      = 1'b0;
        d_flag      = 3'd0;
        d_ra1       = RA1_BUB;
        d_ra2       = RA2_BUB;
        d_wa        = '0;
        d_aluop     = 5'b11111;
        if (!i[8]) begin
            d_ra1      = RAW'(i[3:0]);
            d_ra2      = RAW'(i[3:0]);
            d_wa       = RAW'(i[7:4]);
            d_aluop    = 5'd0;
            d_regwrite = 1'b1;
        end else begin
            case (i[7:6])
                2'b00: begin
                    d_branch = 1'b1;
                    d_immed  = 1'b1;
                    d_isbr   = 1'b1;
                end
                2'b01: begin
                    d_immed    = 1'b1;
                    d_regwrite = 1'b1;
                    d_wa       = RAW'(15);
                end
                2'b10: begin
                    d_wa       = RAW'({2'b10, i[4:3]});
                    d_alusrc   = (i[2:0] != 3'd0);
                    d_regwrite = 1'b1;
                    d_aluop    = {4'b1000, i[5]};
                end
                default: begin
                    if (i[5:4] == 2'b10) begin
                        d_ra1   = RAW'(i[2:0]);
                        d_ra2   = RAW'(i[2:0]);
                        d_aluop = 5'd0;
                        if (!i[3]) begin
                            d_wa       = RAW'(15);
                            d_regwrite = 1'b1;
                            d_memtoreg = 1'b1;
                            d_load     = 1'b1;
                        end else begin
                            d_memwrite = 1'b1;
                        end
                    end else if (i[5:4] == 2'b11) begin
                        d_wa       = RAW'({2'b10, i[1:0]});
                        d_regwrite = 1'b1;
                        if (i[3:2] == 2'b00) d_aluop = 5'b00110;
                        else                 d_bad   = 1'b1;
                    end else if (i[4:3] == 2'b11) begin
                        if (i[2:0] <= 3'd4) begin
                            d_flagwrite = 1'b1;
                            d_flag      = i[2:0];
                        end else begin
                            d_bad = 1'b1;
                        end
                    end else begin
                        d_wa       = RAW'({2'b10, i[1:0]});
                        d_regwrite = 1'b1;
                        case (i[4:2])
                            3'b000:  d_aluop = 5'b00100;
                            3'b001:  d_aluop = 5'b00101;
                            3'b010:  d_aluop = 5'b00000;
                            3'b011:  d_aluop = 5'b00001;
                            3'b100:  d_aluop = 5'b00010;
                            3'b101:  d_aluop = 5'b00011;
                            default: d_bad   = 1'b1;
                        endcase
                    end
                end
            endcase
        end
        if (hi_nz) d_bad = 1'b1;
    end

    assign d_word = {1'b1, d_branch, d_memtoreg, d_memwrite, d_alusrc, d_regwrite,
                     d_flagwrite, d_immed, 1'b0, d_flag, d_ra1, d_ra2, d_wa, d_aluop};

    always_ff @(posedge Clk) begin
        if (!Reset || flush) begin
            state <= RUN;
            cnt   <= 4'd0;
            ctl_q <= BUBBLE;
        end else begin
            ctl_q <= BUBBLE;
            case (state)
                RUN: begin
                    if (accept) begin
                        // Illegal words retire as a NOP and never start a stall.
                        ctl_q <= d_bad ? ILL_WORD : d_word;
                        if (!d_bad && d_load && (MEM_LAT > 0)) begin
                            state <= LWAIT;
                            cnt   <= 4'(MEM_LAT);
                        end else if (!d_bad && d_isbr) begin
                            state <= BWAIT;
                        end
                    end
                end
                LWAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BWAIT: begin
                    if (br_done) state <= RUN;
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign {ctl_valid, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, FlagWrite, Immed,
            illegal, Flag, ReadAddr1, ReadAddr2, WriteAddr, ALUOp} = ctl_q;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: two instances (MEM_LAT=2/OPW=9 and
// MEM_LAT=0/OPW=10) compared cycle by cycle against a behavioural reference.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       valid = 1'b0;
    logic       br_done = 1'b0;
    logic       hi = 1'b0;
    logic [8:0] instr = 9'h000;
    logic [9:0] instr_b;
    assign instr_b = {hi, instr};

    always #5 clk = ~clk;

    logic       rdy_a, cv_a, br_a, m2r_a, mw_a, as_a, rw_a, fw_a, im_a, il_a;
    logic [2:0] fl_a;
    logic [3:0] ra1_a, ra2_a, wa_a, cn_a;
    logic [4:0] op_a;
    logic [1:0] st_a;
    logic       rdy_b, cv_b, br_b, m2r_b, mw_b, as_b, rw_b, fw_b, im_b, il_b;
    logic [2:0] fl_b;
    logic [3:0] ra1_b, ra2_b, wa_b, cn_b;
    logic [4:0] op_b;
    logic [1:0] st_b;

    control_seq #(.OPW(9), .RAW(4), .MEM_LAT(2)) u_dut_a (
        .Clk(clk), .Reset(reset_n), .flush(flush), .instr_valid(valid), .instr(instr),
        .br_done(br_done), .instr_ready(rdy_a), .ctl_valid(cv_a), .Branch(br_a),
        .MemtoReg(m2r_a), .MemWrite(mw_a), .ALUSrc(as_a), .RegWrite(rw_a),
        .FlagWrite(fw_a), .Immed(im_a), .illegal(il_a), .Flag(fl_a), .ReadAddr1(ra1_a),
        .ReadAddr2(ra2_a), .WriteAddr(wa_a), .ALUOp(op_a), .dbg_state(st_a), .dbg_cnt(cn_a)
    );

    control_seq #(.OPW(10), .RAW(4), .MEM_LAT(0)) u_dut_b (
        .Clk(clk), .Reset(reset_n), .flush(flush), .instr_valid(valid), .instr(instr_b),
        .br_done(br_done), .instr_ready(rdy_b), .ctl_valid(cv_b), .Branch(br_b),
        .MemtoReg(m2r_b), .MemWrite(mw_b), .ALUSrc(as_b), .RegWrite(rw_b),
        .FlagWrite(fw_b), .Immed(im_b), .illegal(il_b), .Flag(fl_b), .ReadAddr1(ra1_b),
        .ReadAddr2(ra2_b), .WriteAddr(wa_b), .ALUOp(op_b), .dbg_state(st_b), .dbg_cnt(cn_b)
    );

    logic [28:0] obs_a, obs_b;
    assign obs_a = {cv_a, br_a, m2r_a, mw_a, as_a, rw_a, fw_a, im_a, il_a, fl_a,
                    ra1_a, ra2_a, wa_a, op_a};
    assign obs_b = {cv_b, br_b, m2r_b, mw_b, as_b, rw_b, fw_b, im_b, il_b, fl_b,
                    ra1_b, ra2_b, wa_b, op_b};

    localparam logic [28:0] BUB = {9'b0, 3'b0, 4'd8, 4'd9, 4'd0, 5'd31};

    // Reference state: remaining fetch-hold cycles and pending-branch flag per instance.
    int          stall [2];
    bit          wbr [2];
    int          lat [2] = '{2, 0};
    logic [28:0] exp_q_a[$];
    logic [28:0] exp_q_b[$];
    logic [28:0] exp_a, exp_b;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [28:0] ref_word(input int code);
        logic br, m2r, mw, asrc, rw, fw, imm, ill;
        logic [2:0] fl;
        int r1, r2, wa, op, lo;
        br = 0; m2r = 0; mw = 0; asrc = 0; rw = 0; fw = 0; imm = 0; ill = 0; fl = 0;
        r1 = 8; r2 = 9; wa = 0; op = 31;
        lo = code % 512;
        if (code >= 512) ill = 1;
        else if (lo < 'h100) begin
            r1 = lo % 16; r2 = lo % 16; wa = lo / 16; op = 0; rw = 1;
        end else if (lo < 'h140) begin
            br = 1; imm = 1;
        end else if (lo < 'h180) begin
            imm = 1; rw = 1; wa = 15;
        end else if (lo < 'h1C0) begin
            wa = 8 + (lo / 8) % 4; asrc = (lo % 8) != 0; rw = 1; op = 16 + (lo / 32) % 2;
        end else if (lo < 'h1D8) begin
            wa = 8 + lo % 4; rw = 1;
            case ((lo / 4) % 8)
                0: op = 4;
                1: op = 5;
                2: op = 0;
                3: op = 1;
                4: op = 2;
                default: op = 3;
            endcase
        end else if (lo < 'h1E0) begin
            if (lo % 8 <= 4) begin fw = 1; fl = 3'(lo % 8); end
            else ill = 1;
        end else if (lo < 'h1F0) begin
            r1 = lo % 8; r2 = lo % 8; op = 0;
            if (lo % 16 < 8) begin wa = 15; rw = 1; m2r = 1; end
            else mw = 1;
        end else begin
            wa = 8 + lo % 4; rw = 1;
            if ((lo / 4) % 4 == 0) op = 6;
            else ill = 1;
        end
        if (ill) return {1'b1, 7'b0, 1'b1, BUB[19:0]};
        return {1'b1, br, m2r, mw, asrc, rw, fw, imm, 1'b0, fl,
                4'(r1), 4'(r2), 4'(wa), 5'(op)};
    endfunction

    function automatic logic model_ready(input int k);
        return reset_n && !flush && stall[k] == 0 && !wbr[k];
    endfunction

    task automatic tick();
        int code;
        logic rdy;
        logic [28:0] e;
        for (int k = 0; k < 2; k++) begin
            code = (k == 1) ? int'(instr_b) : int'(instr);
            rdy = model_ready(k);
            e = BUB;
            if (!reset_n || flush) begin
                stall[k] = 0;
                wbr[k] = 0;
            end else begin
                if (stall[k] > 0) stall[k]--;
                else if (wbr[k] && br_done) wbr[k] = 0;
                if (rdy && valid) begin
                    e = ref_word(code);
                    if (code >= 'h1E0 && code < 'h1E8) stall[k] = lat[k];
                    if (code >= 'h100 && code < 'h140) wbr[k] = 1;
                end
            end
            if (k == 0) exp_q_a.push_back(e);
            else exp_q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_a = exp_q_a.pop_front();
        exp_b = exp_q_b.pop_front();
    endtask

    task automatic drive(input logic v, input logic [8:0] code, input logic h,
                         input logic f, input logic bd);
        valid = v; instr = code; hi = h; flush = f; br_done = bd;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            reset_n = 1'b0;
            drive(1'b1, 9'h000, 1'b0, 1'b0, 1'b0);
            if (c > 0) begin
                n_tests++;
                if (rdy_a !== 1'b0) begin
                    n_fail++; $display("FAIL reset_ready got %b exp 0", rdy_a);
                end
            end
            tick();
            n_tests += 2;
            if (obs_a !== BUB) begin n_fail++; $display("FAIL reset_word_a got %h exp %h", obs_a, BUB); end
            if (obs_b !== BUB) begin n_fail++; $display("FAIL reset_word_b got %h exp %h", obs_b, BUB); end
        end
        reset_n = 1'b1;
        drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        n_tests += 2;
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL release_ready_a got %b exp 1", rdy_a); end
        if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL release_ready_b got %b exp 1", rdy_b); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] seq [3] = '{9'h0A3, 9'h1C5, 9'h000};
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, seq[c], 1'b0, 1'b0, 1'b0);
            tick();
            n_tests += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL b2b_word_a[%0d] got %h exp %h", c, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL b2b_word_b[%0d] got %h exp %h", c, obs_b, exp_b); end
            if (c == 0) begin
                n_tests++;
                if (wa_a !== 4'hA || ra1_a !== 4'h3 || op_a !== 5'd0 || rw_a !== 1'b1) begin
                    n_fail++; $display("FAIL mov_fields got wa=%h ra1=%h op=%h rw=%b exp wa=a ra1=3 op=00 rw=1",
                                       wa_a, ra1_a, op_a, rw_a);
                end
            end else if (c == 1) begin
                n_tests++;
                if (wa_a !== 4'h9 || op_a !== 5'b00101 || rw_a !== 1'b1) begin
                    n_fail++; $display("FAIL alu_fields got wa=%h op=%h rw=%b exp wa=9 op=05 rw=1",
                                       wa_a, op_a, rw_a);
                end
            end
        end
    endtask

    task automatic test_load();
        int held = 0;
        int c = 0;
        bit done = 0;
        drive(1'b1, 9'h1E2, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests += 3;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL load_word_a got %h exp %h", obs_a, exp_a); end
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL load_word_b got %h exp %h", obs_b, exp_b); end
        if (m2r_a !== 1'b1 || rw_a !== 1'b1 || wa_a !== 4'hF || ra1_a !== 4'h2) begin
            n_fail++; $display("FAIL load_fields got m2r=%b rw=%b wa=%h ra1=%h exp 1 1 f 2",
                               m2r_a, rw_a, wa_a, ra1_a);
        end
        while (!done && c < 10) begin
            drive(1'b1, 9'h021, 1'b0, 1'b0, 1'b0);
            n_tests += 2;
            if (rdy_a !== model_ready(0)) begin n_fail++; $display("FAIL load_ready_a got %b exp %b", rdy_a, model_ready(0)); end
            if (rdy_b !== model_ready(1)) begin n_fail++; $display("FAIL load_ready_b got %b exp %b", rdy_b, model_ready(1)); end
            if (rdy_a === 1'b1) done = 1;
            else held++;
            tick();
            n_tests += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL load_wait_a got %h exp %h", obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL load_wait_b got %h exp %h", obs_b, exp_b); end
            c++;
        end
        n_tests++;
        if (held != 2) begin n_fail++; $display("FAIL load_stall_cycles got %0d exp 2", held); end
        drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_branch();
        int c = 0;
        drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL brdone_in_run got %b exp 1", rdy_a); end
        drive(1'b1, 9'h105, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests += 2;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL branch_word_a got %h exp %h", obs_a, exp_a); end
        if (br_a !== 1'b1 || im_a !== 1'b1) begin n_fail++; $display("FAIL branch_fields got br=%b imm=%b exp 1 1", br_a, im_a); end
        while (c < 8) begin
            drive(1'b1, 9'h033, 1'b0, 1'b0, c == 5);
            n_tests += 3;
            if (rdy_a !== model_ready(0)) begin n_fail++; $display("FAIL branch_ready_a[%0d] got %b exp %b", c, rdy_a, model_ready(0)); end
            if (rdy_b !== model_ready(1)) begin n_fail++; $display("FAIL branch_ready_b[%0d] got %b exp %b", c, rdy_b, model_ready(1)); end
            if (rdy_a !== (c >= 6)) begin n_fail++; $display("FAIL branch_hold[%0d] got %b exp %b", c, rdy_a, c >= 6); end
            tick();
            n_tests += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL branch_wait_a got %h exp %h", obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL branch_wait_b got %h exp %h", obs_b, exp_b); end
            c++;
        end
    endtask

    task automatic test_illegal();
        logic [9:0] words [5] = '{10'h1DF, 10'h1DD, 10'h1F4, 10'h200, 10'h3E2};
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, words[c][8:0], words[c][9], 1'b0, 1'b0);
            tick();
            n_tests += 3;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL illegal_word_a[%0d] got %h exp %h", c, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL illegal_word_b[%0d] got %h exp %h", c, obs_b, exp_b); end
            if (cv_b !== 1'b1 || il_b !== 1'b1 || rw_b !== 1'b0 || fw_b !== 1'b0 || op_b !== 5'h1F) begin
                n_fail++; $display("FAIL illegal_fields[%0d] got cv=%b il=%b rw=%b fw=%b op=%h exp 1 1 0 0 1f",
                                   c, cv_b, il_b, rw_b, fw_b, op_b);
            end
            drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL illegal_state[%0d] got ready %b exp 1", c, rdy_b); end
            if (c == 4) begin
                for (int w = 0; w < 3; w++) begin
                    tick();
                    n_tests++;
                    if (obs_a !== exp_a) begin n_fail++; $display("FAIL illegal_drain_a got %h exp %h", obs_a, exp_a); end
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 9'h1E2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9'h044, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", rdy_a); end
        tick();
        n_tests += 2;
        if (obs_a !== BUB) begin n_fail++; $display("FAIL flush_bubble_a got %h exp %h", obs_a, BUB); end
        if (obs_b !== BUB) begin n_fail++; $display("FAIL flush_bubble_b got %h exp %h", obs_b, BUB); end
        drive(1'b1, 9'h055, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL flush_run got %b exp 1", rdy_a); end
        tick();
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL flush_after_a got %h exp %h", obs_a, exp_a); end
        drive(1'b1, 9'h105, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9'h066, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b0;
        drive(1'b1, 9'h066, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        drive(1'b1, 9'h066, 1'b0, 1'b0, 1'b0);
        n_tests += 3;
        if (obs_a !== BUB) begin n_fail++; $display("FAIL reset_bwait_word got %h exp %h", obs_a, BUB); end
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_bwait_ready_a got %b exp 1", rdy_a); end
        if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_bwait_ready_b got %b exp 1", rdy_b); end
        tick();
    endtask

    task automatic test_random();
        logic [8:0] code;
        for (int c = 0; c < 400; c++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            code = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) code = 9'($urandom_range('h100, 'h13F));
            if ($urandom_range(0, 3) == 0) code = 9'($urandom_range('h1C0, 'h1FF));
            drive($urandom_range(0, 3) != 0, code, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0);
            n_tests += 2;
            if (rdy_a !== model_ready(0)) begin n_fail++; $display("FAIL rand_ready_a[%0d] got %b exp %b", c, rdy_a, model_ready(0)); end
            if (rdy_b !== model_ready(1)) begin n_fail++; $display("FAIL rand_ready_b[%0d] got %b exp %b", c, rdy_b, model_ready(1)); end
            tick();
            n_tests += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL rand_word_a[%0d] got %h exp %h", c, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL rand_word_b[%0d] got %h exp %h", c, obs_b, exp_b); end
        end
    endtask

    initial begin
        stall[0] = 0; stall[1] = 0; wbr[0] = 0; wbr[1] = 0;
        test_reset();
        test_back_to_back();
        test_load();
        test_branch();
        test_illegal();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
